// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - hazard-unit stage control and per-stage pipeline payloads
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_NOP    = 2'd2
  } pipe_state_t;

  typedef enum logic [2:0] {
    RTYPE, ITYPE, LOAD, STORE, BRANCH, JUMP
  } op_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  typedef struct packed {
    op_t         op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] imm;
    logic        reg_write;
    logic        d_wen;
    logic        d_ren;
  } idex_t;

  typedef struct packed {
    op_t         op;
    logic [31:0] alu_out;
    logic [31:0] wdat;
    logic [4:0]  wsel;
    logic        reg_write;
    logic        d_wen;
    logic        d_ren;
  } exmem_t;

  typedef struct packed {
    logic [31:0] wdat;
    logic [4:0]  wsel;
    logic        reg_write;
  } memwb_t;

  // Bubble encodings: every write-enable is 0, so a drained stage has no side effects.
  localparam ifid_t  IFID_NOP  = '0;
  localparam idex_t  IDEX_NOP  = '0;
  localparam exmem_t EXMEM_NOP = '{op: RTYPE, default: '0};
  localparam memwb_t MEMWB_NOP = '0;

endpackage

// File: rtl/pipeline_elastic_stage.sv
// rtl/pipeline_elastic_stage.sv - elastic inter-stage buffer with hazard control and stall counter
module pipeline_elastic_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  pipe_state_t                state,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             push, pop;

  // Explicit wrap so non-power-of-2 depths never address past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count_q < CW'(DEPTH)) && (state == PIPE_ENABLE);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : NOP_VALUE;
  assign occupancy = count_q;
  assign stall_cnt = stall_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && (state != PIPE_STALL);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    if (state == PIPE_NOP) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    // Flush does not clear the counter; only reset does.
    if (out_valid && (!out_ready || state == PIPE_STALL) && (stall_q != '1))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: doc/pipeline_elastic_stage.md
# pipeline_elastic_stage

Parametrised, elastic successor to the fixed inter-stage latches between the pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque packed payload of `WIDTH` bits through a `DEPTH`-entry circular buffer with a valid/ready handshake. It also honours the hazard unit's per-stage control (`PIPE_ENABLE` / `PIPE_STALL` / `PIPE_NOP`), injects a parametrised bubble value, and counts back-pressure cycles for performance analysis.

## Interface
Parameters:
- `WIDTH`, 32: payload width in bits (≥1).
- `DEPTH`, 2: buffer entries, legal 1–4. Use 2 for full throughput without a combinational ready path.
- `NOP_VALUE`, '0: payload driven when the stage is empty, i.e. the bubble encoding.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `CLK`, input, 1: clock, rising edge.
- `nRST`, input, 1: asynchronous active-low reset.
- `state`, input, `pipe_state_t`: hazard-unit control, one of `PIPE_ENABLE`, `PIPE_STALL`, `PIPE_NOP`.
- `in_valid`, input, 1: upstream payload valid.
- `in_data`, input, `WIDTH`: upstream payload.
- `in_ready`, output, 1: stage accepts a push this cycle.
- `out_valid`, output, 1: head entry valid.
- `out_data`, output, `WIDTH`: head payload, or `NOP_VALUE` when empty.
- `out_ready`, input, 1: downstream accepts the head this cycle.
- `occupancy`, output, $clog2(DEPTH+1): current entry count.
- `stall_cnt`, output, `CNT_W`: saturating count of back-pressure cycles.

## Operation
- Storage is a circular buffer with `wr_ptr`, `rd_ptr` and `count`. Pointers wrap modulo `DEPTH`, including non-power-of-2 depths: an explicit compare to `DEPTH-1` resets the pointer to 0.
- A push occurs when `in_valid && in_ready`. A pop occurs when `out_valid && out_ready && state != PIPE_STALL`.
- `in_ready = (count < DEPTH) && (state == PIPE_ENABLE)`. It depends only on registered state and `state`, and never on `out_ready`.
- `out_valid = (count != 0)`. `out_data` is `mem[rd_ptr]` when valid, else `NOP_VALUE`.
- Behaviour per `state`:
  - `PIPE_ENABLE`: normal push and pop.
  - `PIPE_STALL`: no push and no pop; contents and pointers hold. `out_valid` and `out_data` stay stable.
  - `PIPE_NOP`: synchronous flush. On the next edge `count`, `wr_ptr` and `rd_ptr` go to 0, and any push or pop in that cycle is discarded.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance. This is legal when full because `in_ready` is 0 when full, so a full buffer cannot push.
- Empty: no pop. `out_data` is `NOP_VALUE`, so a downstream consumer sees a bubble, for example `RegWrite` = 0 and `dWEN` = 0 when `NOP_VALUE` = 0.
- `stall_cnt` increments when `out_valid && (!out_ready || state == PIPE_STALL)`. It saturates at all-ones and is never cleared except by reset. A flush does not clear it.

## Timing
- Latency is 1 cycle: data pushed at edge N is visible on `out_data` with `out_valid` = 1 after edge N.
- Throughput is 1 item per cycle when `DEPTH` ≥ 2 and downstream is always ready. With `DEPTH` = 1, throughput is 1 item per 2 cycles.
- A flush takes effect at the next edge, so `out_valid` = 0 one cycle after `PIPE_NOP` is sampled.
- Reset values, asynchronous on `nRST` low:
  - `count`, `wr_ptr`, `rd_ptr` = 0.
  - `out_valid` = 0, `out_data` = `NOP_VALUE`, `in_ready` = 1 (given `PIPE_ENABLE`), `occupancy` = 0, `stall_cnt` = 0.
  - Contents of `mem` are don't-care.
- Reset asserted mid-transfer discards all entries. The first push after `nRST` rises is accepted on the first edge.

## Structure
- `pipe_state_t` (`PIPE_ENABLE`, `PIPE_STALL`, `PIPE_NOP`) lives in `cpu_types_pkg`.
- Per-stage payload structs are also declared in `cpu_types_pkg` (`ifid_t`, `idex_t`, `exmem_t`, `memwb_t`). Instantiations set `WIDTH = $bits(<struct>)` and `NOP_VALUE` to the struct's bubble constant; for EX/MEM, `op` = `RTYPE` and all other fields 0.
- No sub-module. Storage, pointers and counter are all local to this block.

## Test plan
- Reset, then a single push of 0xDEADBEEF with `out_ready` = 1: `out_valid` = 1 with `out_data` = 0xDEADBEEF one cycle later, then `out_valid` = 0 and `out_data` = `NOP_VALUE`.
- `DEPTH` = 2, stream of 10 words with `out_ready` = 1 throughout: 10 words out in order over 10 consecutive cycles, `occupancy` ≤ 1.
- `DEPTH` = 3, `out_ready` = 0, push 4 words: `in_ready` drops after the 3rd, `occupancy` = 3. Then drain: words 1–3 come out in order and the pointers wrap correctly on the next 3 pushes.
- `state` = `PIPE_STALL` for 5 cycles with 2 entries held: `out_data` is unchanged, no push is accepted, and `stall_cnt` increases by 5.
- `PIPE_NOP` with 2 entries and a simultaneous push: next cycle `occupancy` = 0 and `out_data` = `NOP_VALUE`; `stall_cnt` is retained.
- `CNT_W` = 4, hold back-pressure for 20 cycles: `stall_cnt` saturates at 15.
